// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide sequencer: radix-2 Booth MUL and restoring DIV
// over WIDTH iterations, with HI/LO result registers and busy/done handshake.
module muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   acc;     // Booth accumulator / division remainder
   logic [WIDTH-1:0] mq;      // multiplier / quotient
   logic             q1;
   logic [WIDTH-1:0] mcand;   // multiplicand / divisor magnitude
   logic             neg_q;
   logic             neg_r;
   logic             zflag;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH:0]   mul_acc;
   logic [WIDTH-1:0] mul_mq;
   logic [WIDTH:0]   rem_s;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   div_acc;
   logic [WIDTH-1:0] div_mq;
   logic             last;

   always_comb begin
      a_mag = a[WIDTH-1] ? -a : a;
      b_mag = b[WIDTH-1] ? -b : b;
      last  = (cnt == CNT_W'(WIDTH - 1));

      case ({mq[0], q1})
         2'b01:   booth_sum = acc + {mcand[WIDTH-1], mcand};
         2'b10:   booth_sum = acc - {mcand[WIDTH-1], mcand};
         default: booth_sum = acc;
      endcase
      mul_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      mul_mq  = {booth_sum[0], mq[WIDTH-1:1]};

      rem_s = {acc[WIDTH-1:0], mq[WIDTH-1]};
      trial = rem_s - {1'b0, mcand};
      if (trial[WIDTH]) begin
         div_acc = rem_s;
         div_mq  = {mq[WIDTH-2:0], 1'b0};
      end else begin
         div_acc = trial;
         div_mq  = {mq[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         cnt      <= '0;
         acc      <= '0;
         mq       <= '0;
         q1       <= 1'b0;
         mcand    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         zflag    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt      <= '0;
                  busy     <= 1'b1;
                  div_zero <= 1'b0;
                  q1       <= 1'b0;
                  zflag    <= 1'b0;
                  if (!op) begin
                     acc   <= '0;
                     mq    <= b;
                     mcand <= a;
                     state <= S_MUL;
                  end else if (b == '0) begin
                     // Divide-by-zero passes through FIX untouched so results land two edges after accept.
                     acc   <= {a[WIDTH-1], a};
                     mq    <= '1;
                     mcand <= b;
                     zflag <= 1'b1;
                     state <= S_FIX;
                  end else begin
                     acc   <= '0;
                     mq    <= a_mag;
                     mcand <= b_mag;
                     neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                     neg_r <= a[WIDTH-1];
                     state <= S_DIV;
                  end
               end
            end
            S_MUL: begin
               acc <= mul_acc;
               mq  <= mul_mq;
               q1  <= mq[0];
               cnt <= cnt + 1'b1;
               if (last) state <= S_FIN;
            end
            S_DIV: begin
               acc <= div_acc;
               mq  <= div_mq;
               cnt <= cnt + 1'b1;
               if (last) state <= S_FIX;
            end
            S_FIX: begin
               if (!zflag) begin
                  if (neg_q) mq  <= -mq;
                  if (neg_r) acc <= -acc;
               end
               state <= S_FIN;
            end
            S_FIN: begin
               hi       <= acc[WIDTH-1:0];
               lo       <= mq;
               busy     <= 1'b0;
               done     <= 1'b1;
               div_zero <= zflag;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: driver pushes reference results, monitor checks on done.
module tb_muldiv_seq;

   logic        clock = 1'b0;
   logic        clear_n = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clock(clock), .clear_n(clear_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          fails = 0;
   logic        prev_done = 1'b0;

   always @(posedge clock) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model from signed arithmetic; SV / and % truncate toward zero.
   function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
      exp_t   e;
      longint sx, sy, p, q, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      e.dz = 1'b0;
      if (!o) begin
         p = sx * sy;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (y == 0) begin
         e.hi = x;
         e.lo = 32'hFFFF_FFFF;
         e.dz = 1'b1;
      end else begin
         q = sx / sy;
         r = sx % sy;
         e.hi = r[31:0];
         e.lo = q[31:0];
      end
      e.due = 0;
      return e;
   endfunction

   // Called just after a negedge while the DUT is idle; returns one negedge after accept.
   task automatic drive(input logic o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      e = model(o, x, y);
      e.due = cyc + 1 + (!o ? 33 : (y == 0 ? 2 : 34));
      sb.push_back(e);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clock);
      start = 1'b0;
      chk("busy_after_accept", {63'd0, busy}, 64'd1);
   endtask

   task automatic wait_empty();
      int unsigned n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   task automatic wait_done();
      int unsigned n = 0;
      while (!done && n < 60) begin
         @(negedge clock);
         n++;
      end
      if (!done) chk("done_wait_timeout", 64'd0, 64'd1);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (clear_n && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("hi", {32'd0, hi}, {32'd0, e.hi});
            chk("lo", {32'd0, lo}, {32'd0, e.lo});
            chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
            chk("latency", 64'(cyc), 64'(e.due));
            chk("busy_low_at_done", {63'd0, busy}, 64'd0);
            chk("done_single_pulse", {63'd0, prev_done}, 64'd0);
         end
      end
      prev_done = done;
   end

   initial begin
      logic [31:0] x, y;
      logic        o;
      repeat (2) @(negedge clock);
      clear_n = 1'b1;
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_dz", {63'd0, div_zero}, 64'd0);
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);

      @(negedge clock); drive(1'b0, 32'd7, -32'sd3); wait_empty();
      @(negedge clock); drive(1'b0, 32'h8000_0000, 32'h8000_0000); wait_empty();
      @(negedge clock); drive(1'b0, 32'hFFFF_FFFF, 32'h0000_0001); wait_empty();
      @(negedge clock); drive(1'b1, -32'sd7, 32'd2); wait_empty();
      @(negedge clock); drive(1'b1, 32'd100, -32'sd7); wait_empty();
      @(negedge clock); drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_empty();
      @(negedge clock); drive(1'b1, 32'd5, 32'd0); wait_empty();
      chk("hi_holds", {32'd0, hi}, 64'd5);
      @(negedge clock); drive(1'b0, 32'd2, 32'd3);
      chk("dz_cleared_on_accept", {63'd0, div_zero}, 64'd0);
      wait_empty();

      // Start pulses during a MUL must be ignored; next command issued in the done cycle.
      @(negedge clock); drive(1'b0, 32'd1234, -32'sd567);
      repeat (4) @(negedge clock);
      start = 1'b1; op = 1'b1; a = 32'd99; b = 32'd0;
      @(negedge clock); start = 1'b0;
      repeat (14) @(negedge clock);
      start = 1'b1; op = 1'b0; a = 32'hDEAD; b = 32'hBEEF;
      @(negedge clock); start = 1'b0;
      wait_done();
      drive(1'b1, 32'd1000, 32'd33);
      wait_empty();

      // Reset in the middle of a DIV aborts it.
      @(negedge clock); drive(1'b1, 32'd5000, 32'd7);
      repeat (9) @(negedge clock);
      clear_n = 1'b0;
      sb.delete();
      @(negedge clock);
      clear_n = 1'b1;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_hi", {32'd0, hi}, 64'd0);
      chk("abort_lo", {32'd0, lo}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      repeat (40) @(negedge clock);
      drive(1'b0, 32'd3, 32'd4); wait_empty();

      for (int i = 0; i < 40; i++) begin
         o = 1'($urandom_range(0, 1));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: x = 32'h8000_0000;
            2: y = 32'hFFFF_FFFF;
            3: y = 32'($signed(y) >>> 20);
            default: ;
         endcase
         @(negedge clock);
         drive(o, x, y);
         if (i % 3 == 0) begin
            wait_done();
         end else begin
            wait_empty();
         end
      end
      wait_empty();
      repeat (3) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
